nio2_sys_led_fader: RTL and testbench
=====================================

NIO2_SYS_LED_FADER -- requirements
Module: nio2_sys_led_fader

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8: number of LED channels.
REQ-002 SHALL have parameter PRESCALE_DIV, default 256: clk cycles per PWM count tick, range 1..65535.
REQ-003 SHALL have parameter FADE_STEP, default 4: level change per PWM period, range 1..255.
REQ-004 SHALL have port clk  input  1: sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port pattern_in  input  NUM_LEDS: target on/off pattern, driven by LED PIO out_port.
REQ-007 SHALL have port fade_bypass  input  1: when 1, levels jump straight to target.
REQ-008 SHALL have port led_out  output  NUM_LEDS: registered PWM drive to the LED pins.
REQ-009 SHALL have port period_start  output  1: one-cycle pulse on each PWM period boundary.
REQ-010 SHALL have port busy  output  1: high while any level is off its target endpoint.

Function
REQ-011 SHALL run a prescaler counting 0..PRESCALE_DIV-1; tick asserts in the cycle the count equals PRESCALE_DIV-1, then the count wraps to 0.
REQ-012 SHALL keep an 8-bit pwm_cnt that increments on tick and wraps 255->0.
REQ-013 SHALL define boundary as tick AND pwm_cnt==255; period length = 256*PRESCALE_DIV cycles.
REQ-014 SHALL sample pattern_in only in the boundary cycle; pattern changes between boundaries have no effect.
REQ-015 SHALL keep an 8-bit level per LED, updated only at boundary: pattern bit 1 -> min(level+FADE_STEP,255); bit 0 -> max(level-FADE_STEP,0); 9-bit intermediate, saturating, no wrap.
REQ-016 SHALL, with fade_bypass=1 at boundary, set level to 255 (bit 1) or 0 (bit 0) in that one update.
REQ-017 SHALL register led_out[i] = (level[i]==255) OR (level[i] > pwm_cnt); level 0 -> constant 0; level 255 -> constant 1.
REQ-018 SHALL produce led_out one clk after the pwm_cnt/level values it is computed from.
REQ-019 SHALL register period_start high for exactly the cycle after each boundary.
REQ-020 SHALL register busy = OR over i of (level[i] != (target[i] ? 255 : 0)), where target is the pattern last sampled at boundary.
REQ-021 SHALL make every update depend only on pattern_in and fade_bypass as sampled at boundary; mid-period changes to either input are ignored.

Reset
REQ-022 SHALL, while reset=1 at a clk edge, clear prescaler, pwm_cnt, all levels, target, led_out, period_start, busy to 0.
REQ-023 SHALL, on reset asserted mid-fade, discard all fade progress; the first boundary after release occurs 256*PRESCALE_DIV cycles after reset deasserts.
REQ-024 SHALL have reset override every other input in the same cycle.

Structure
REQ-025 SHALL place the constants PWM_WIDTH=8, LEVEL_MAX=255 and the default parameter values in shared package nio2_sys_led_pkg.
REQ-026 SHALL implement one per-LED sub-module, nio2_sys_led_fader_channel (level register, saturating update, compare, target bit), instanced NUM_LEDS times.
REQ-027 SHALL keep the prescaler, pwm_cnt and busy/period_start logic in the top level, shared by all channels.

Verification (PRESCALE_DIV=1, FADE_STEP=4, NUM_LEDS=8)
REQ-028 SHALL check: hold reset 3 cycles, then pattern_in=0xFF -> all outputs 0 until the first boundary at cycle 256; then level=4 and each led_out is high exactly 4 of the next 256 cycles; busy=1.
REQ-029 SHALL check: pattern_in=0xFF held -> level reaches 252 after 63 boundaries and saturates at 255 after 64; led_out constant 0xFF; busy falls to 0.
REQ-030 SHALL check: from all levels at 255, pattern_in=0x00 -> 251 after 1 boundary; 0 after 64 boundaries; led_out constant 0x00; no underflow.
REQ-031 SHALL check: pattern_in changes 0x00->0x0F at pwm_cnt=100 -> levels unchanged until the next boundary; then bits 3:0 = 4 and bits 7:4 = 0.
REQ-032 SHALL check: fade_bypass=1, pattern_in=0xA5 -> at first boundary levels = 255/0 per bit; led_out=0xA5 continuously from 1 cycle later; busy=0.
REQ-033 SHALL check: reset pulse at level 128 during a fade -> all levels and outputs 0 next cycle; fade restarts from 0; period_start pulses once per 256 cycles throughout.

Source files
------------

// File: rtl/nio2_sys_led_pkg.sv
// rtl/nio2_sys_led_pkg.sv - shared constants, types and saturating step helper for the LED fader
// Purpose: PWM width, full-scale level, default parameter values and the
//          9-bit saturating level update used by every fader channel.
package nio2_sys_led_pkg;

    localparam int PWM_WIDTH            = 8;
    localparam int LEVEL_MAX            = 255;
    localparam int DEF_NUM_LEDS         = 8;
    localparam int DEF_PRESCALE_DIV     = 256;
    localparam int DEF_FADE_STEP        = 4;

    typedef logic [PWM_WIDTH-1:0] level_t;

    // Move level one step toward the endpoint selected by up; the ninth bit
    // catches the carry/borrow so the result clamps instead of wrapping.
    function automatic level_t sat_step(input level_t level, input logic up, input level_t step);
        logic [PWM_WIDTH:0] wide;
        level_t             result;
        if (up) begin
            wide   = {1'b0, level} + {1'b0, step};
            result = wide[PWM_WIDTH] ? level_t'(LEVEL_MAX) : wide[PWM_WIDTH-1:0];
        end else begin
            wide   = {1'b0, level} - {1'b0, step};
            result = wide[PWM_WIDTH] ? '0 : wide[PWM_WIDTH-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/nio2_sys_led_fader_channel.sv
// rtl/nio2_sys_led_fader_channel.sv - one LED channel: level register, saturating fade, PWM compare
// Ports:
//   clk_i, reset_i   : clock, synchronous active-high reset
//   boundary_i       : PWM period boundary strobe from the shared timebase
//   pattern_bit_i    : target bit for this LED (sampled only at boundary)
//   bypass_i         : jump straight to the endpoint at boundary
//   pwm_cnt_i        : shared PWM counter
//   led_o            : registered PWM drive
//   off_target_o     : level not yet at the endpoint of the sampled target
module nio2_sys_led_fader_channel
    import nio2_sys_led_pkg::*;
#(
    parameter int FADE_STEP = DEF_FADE_STEP
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 boundary_i,
    input  logic                 pattern_bit_i,
    input  logic                 bypass_i,
    input  logic [PWM_WIDTH-1:0] pwm_cnt_i,
    output logic                 led_o,
    output logic                 off_target_o
);

    localparam level_t STEP = level_t'(FADE_STEP);
    localparam level_t FULL = level_t'(LEVEL_MAX);

    level_t level_q, level_d;
    logic   target_q, target_d;
    logic   led_q;

    always_comb begin
        level_d  = level_q;
        target_d = target_q;
        if (boundary_i) begin
            target_d = pattern_bit_i;
            if (bypass_i) begin
                level_d = pattern_bit_i ? FULL : '0;
            end else begin
                level_d = sat_step(level_q, pattern_bit_i, STEP);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            level_q  <= '0;
            target_q <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            level_q  <= level_d;
            target_q <= target_d;
            // Full scale forces a constant 1; the compare alone would drop
            // the output when pwm_cnt reaches 255.
            led_q    <= (level_q == FULL) || (level_q > pwm_cnt_i);
        end
    end

    assign led_o        = led_q;
    assign off_target_o = (level_q != (target_q ? FULL : '0));

endmodule

// File: rtl/nio2_sys_led_fader.sv
// rtl/nio2_sys_led_fader.sv - multi-channel LED PWM fader with shared prescaler and period timebase
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   pattern_in    : target on/off pattern, sampled at each PWM period boundary
//   fade_bypass   : when set at boundary, levels jump to their endpoints
//   led_out       : registered PWM drive per LED
//   period_start  : one-cycle pulse in the cycle after each period boundary
//   busy          : some level is still off its target endpoint
module nio2_sys_led_fader
    import nio2_sys_led_pkg::*;
#(
    parameter int NUM_LEDS     = DEF_NUM_LEDS,
    parameter int PRESCALE_DIV = DEF_PRESCALE_DIV,
    parameter int FADE_STEP    = DEF_FADE_STEP
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_LEDS-1:0] pattern_in,
    input  logic                fade_bypass,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                period_start,
    output logic                busy
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE_DIV - 1);

    logic [15:0]          presc_q, presc_d;
    logic [PWM_WIDTH-1:0] pwm_q, pwm_d;
    logic                 period_start_q;
    logic                 busy_q;
    logic                 tick;
    logic                 boundary;
    logic [NUM_LEDS-1:0]  off_target;

    assign tick     = (presc_q == PRESC_LAST);
    assign boundary = tick && (pwm_q == PWM_WIDTH'(LEVEL_MAX));

    always_comb begin
        presc_d = tick ? '0 : presc_q + 16'd1;
        // 8-bit add wraps 255 -> 0 naturally.
        pwm_d   = tick ? pwm_q + 1'b1 : pwm_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q        <= '0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            pwm_q          <= pwm_d;
            period_start_q <= boundary;
            busy_q         <= |off_target;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
        nio2_sys_led_fader_channel #(
            .FADE_STEP (FADE_STEP)
        ) u_chan (
            .clk_i         (clk),
            .reset_i       (reset),
            .boundary_i    (boundary),
            .pattern_bit_i (pattern_in[i]),
            .bypass_i      (fade_bypass),
            .pwm_cnt_i     (pwm_q),
            .led_o         (led_out[i]),
            .off_target_o  (off_target[i])
        );
    end

    assign period_start = period_start_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_nio2_sys_led_fader.sv
// tb/tb_nio2_sys_led_fader.sv - table-driven self-checking bench for nio2_sys_led_fader
module tb_nio2_sys_led_fader;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] pattern_in = '0;
    logic         fade_bypass = 1'b0;
    logic [N-1:0] led_out;
    logic         period_start;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;
    int duty_a [N];
    int busy_s;

    typedef struct {
        logic [7:0] pat;
        logic       byp;
        int         nb;
        int         exp_on;
        int         exp_off;
        int         exp_busy;
    } vec_t;

    vec_t tbl [8];

    nio2_sys_led_fader #(
        .NUM_LEDS     (N),
        .PRESCALE_DIV (1),
        .FADE_STEP    (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pattern_in   (pattern_in),
        .fade_bypass  (fade_bypass),
        .led_out      (led_out),
        .period_start (period_start),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int duty_of(input int lvl);
        return (lvl == 255) ? 256 : lvl;
    endfunction

    // Wait for n period_start pulses, each expected exactly 256 cycles after
    // the previous one (or after the call point).
    task automatic wait_ps(input string name, input int n);
        int first_bad = 256;
        int cnt;
        for (int p = 0; p < n; p++) begin
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (!period_start && cnt < 300);
            if (cnt != 256 && first_bad == 256) first_bad = cnt;
        end
        check(name, first_bad, 256);
    endtask

    // Called at a period_start cycle: counts led_out high cycles over the
    // following full period and captures busy once the new levels settle.
    task automatic measure(input string name);
        for (int i = 0; i < N; i++) duty_a[i] = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            if (k == 0) busy_s = int'(busy);
            for (int i = 0; i < N; i++) duty_a[i] += int'(led_out[i]);
        end
        check({name, "_ps_end"}, int'(period_start), 1);
    endtask

    initial begin
        int quiet;
        int cnt;

        tbl[0] = '{8'hFF, 1'b0, 61, 252,   0, 1};
        tbl[1] = '{8'hFF, 1'b0,  1, 255,   0, 0};
        tbl[2] = '{8'h00, 1'b0,  1,   0, 251, 1};
        tbl[3] = '{8'h00, 1'b0, 61,   0,   3, 1};
        tbl[4] = '{8'h00, 1'b0,  1,   0,   0, 0};
        tbl[5] = '{8'hA5, 1'b1,  1, 255,   0, 0};
        tbl[6] = '{8'h5A, 1'b0,  1,   4, 251, 1};
        tbl[7] = '{8'h5A, 1'b1,  1, 255,   0, 0};

        // Reset held 3 cycles, then first fade-in period.
        pattern_in = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_led", int'(led_out), 0);
        check("rst_ps", int'(period_start), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;
        quiet = 0;
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk);
            if (k < 256) begin
                if (led_out != 0 || period_start || busy) quiet++;
            end else begin
                check("first_boundary_ps", int'(period_start), 1);
            end
        end
        check("pre_boundary_quiet", quiet, 0);
        measure("first");
        for (int i = 0; i < N; i++) check($sformatf("first_duty%0d", i), duty_a[i], 4);
        check("first_busy", busy_s, 1);

        // Table steps, each starting in a period_start cycle.
        for (int s = 0; s < 8; s++) begin
            pattern_in  = tbl[s].pat;
            fade_bypass = tbl[s].byp;
            wait_ps($sformatf("step%0d_spacing", s), tbl[s].nb);
            measure($sformatf("step%0d", s));
            for (int i = 0; i < N; i++)
                check($sformatf("step%0d_duty%0d", s, i), duty_a[i],
                      duty_of(tbl[s].pat[i] ? tbl[s].exp_on : tbl[s].exp_off));
            check($sformatf("step%0d_busy", s), busy_s, tbl[s].exp_busy);
        end

        // Reset mid-fade at level 128.
        fade_bypass = 1'b0;
        pattern_in  = 8'hFF;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst2_led", int'(led_out), 0);
        wait_ps("fade128_spacing", 32);
        repeat (100) @(negedge clk);
        check("lvl128_led", int'(led_out), 8'hFF);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_led", int'(led_out), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_ps", int'(period_start), 0);
        wait_ps("midrst_spacing", 1);
        measure("restart");
        for (int i = 0; i < N; i++) check($sformatf("restart_duty%0d", i), duty_a[i], 4);
        check("restart_busy", busy_s, 1);

        // Mid-period changes to pattern_in and fade_bypass.
        pattern_in = 8'h00;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        pattern_in  = 8'h0F;
        fade_bypass = 1'b1;
        repeat (50) @(negedge clk);
        fade_bypass = 1'b0;
        cnt = 150;
        quiet = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (led_out != 0) quiet++;
        end while (!period_start && cnt < 300);
        check("midchg_boundary_at", cnt, 256);
        check("midchg_quiet", quiet, 0);
        measure("midchg");
        for (int i = 0; i < N; i++)
            check($sformatf("midchg_duty%0d", i), duty_a[i], (i < 4) ? 4 : 0);
        check("midchg_busy", busy_s, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
